multicycle_ctrl: RTL and testbench

- Multicycle control unit that drives the yIF/yID/yEX/yDM/yWB datapath in place of bench-driven control signals.
- Latches the fetched instruction's control fields and sequences FETCH→DECODE→EXEC→MEM→WB.
- Emits per-cycle strobes (RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op) plus PC-update controls.
- Stalls on data-memory readiness, traps on illegal opcodes, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle control unit for the yIF/yID/yEX/yDM/yWB datapath. It latches
// the fetched instruction into an internal IR and walks it through
// FETCH -> DECODE -> EXEC -> MEM -> WB, emitting the per-cycle datapath
// strobes and PC-update controls. Data-memory accesses stall until
// mem_ready, illegal opcodes or R-type funct3 values park the unit in TRAP
// until reset, and every retired instruction bumps a wrapping counter.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   ins        instruction word from yIF (only sampled in FETCH)
//   zero       ALU zero flag from yEX (selects the beq target)
//   mem_ready  data memory ready; 1 = access completes this cycle
//   IRWrite    latch ins into IR / advance fetch
//   RegWrite   register file write enable
//   ALUSrc     ALU B source: 0 = rd2, 1 = imm
//   MemRead    data memory read
//   MemWrite   data memory write
//   Mem2Reg    writeback source: 1 = memOut, 0 = ALU z
//   Link       writeback source = PC+4 (jal); overrides Mem2Reg
//   op         ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
//   PCWrite    load PC this cycle
//   PCSel      00 = PC+4, 01 = branch target, 10 = jTarget
//   state      current state (debug)
//   trap       sticky illegal-instruction flag
//   retired    retired-instruction count (wraps silently)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ins,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             IRWrite,
   output logic             RegWrite,
   output logic             ALUSrc,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             Mem2Reg,
   output logic             Link,
   output logic [2:0]       op,
   output logic             PCWrite,
   output logic [1:0]       PCSel,
   output logic [2:0]       state,
   output logic             trap,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'b000,
      S_DECODE = 3'b001,
      S_EXEC   = 3'b010,
      S_MEM    = 3'b011,
      S_WB     = 3'b100,
      S_TRAP   = 3'b111
   } state_t;

   localparam logic [6:0] OPC_R    = 7'h33;
   localparam logic [6:0] OPC_ADDI = 7'h13;
   localparam logic [6:0] OPC_LW   = 7'h03;
   localparam logic [6:0] OPC_SW   = 7'h23;
   localparam logic [6:0] OPC_BEQ  = 7'h63;
   localparam logic [6:0] OPC_JAL  = 7'h6F;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t      cur;
   logic [31:0] ir;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [4:0] rd;
   logic       is_r, is_addi, is_lw, is_sw, is_beq, is_jal, legal;
   logic [2:0] r_op;
   logic       r_ok;

   // Immediate and register-select bits of IR belong to the datapath, not
   // to control; folding them here keeps the full IR visible without
   // leaving dangling bits.
   logic unused_ir_bits;
   assign unused_ir_bits = ^{ir[31], ir[29:15]};

   assign opcode  = ir[6:0];
   assign funct3  = ir[14:12];
   assign rd      = ir[11:7];
   assign is_r    = (opcode == OPC_R);
   assign is_addi = (opcode == OPC_ADDI);
   assign is_lw   = (opcode == OPC_LW);
   assign is_sw   = (opcode == OPC_SW);
   assign is_beq  = (opcode == OPC_BEQ);
   assign is_jal  = (opcode == OPC_JAL);
   assign legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_jal;
   assign state   = cur;

   // R-type ALU operation from funct3 (and bit 30 for add/sub); r_ok
   // flags the funct3 values this datapath actually implements.
   always_comb begin
      r_op = ALU_ADD;
      r_ok = 1'b1;
      case (funct3)
         3'd0:    r_op = ir[30] ? ALU_SUB : ALU_ADD;
         3'd6:    r_op = ALU_OR;
         3'd7:    r_op = ALU_AND;
         3'd2:    r_op = ALU_SLT;
         default: r_ok = 1'b0;
      endcase
   end

   // Sequencer: state, IR, sticky trap and the retired counter. Retirement
   // happens exactly where the PCWrite pulse is produced (beq in EXEC, sw
   // in MEM on ready, everything else in WB).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur     <= S_FETCH;
         ir      <= '0;
         trap    <= 1'b0;
         retired <= '0;
      end else begin
         case (cur)
            S_FETCH: begin
               ir  <= ins;
               cur <= S_DECODE;
            end
            S_DECODE: begin
               if (legal) begin
                  cur <= S_EXEC;
               end else begin
                  cur  <= S_TRAP;
                  trap <= 1'b1;
               end
            end
            S_EXEC: begin
               if (is_r) begin
                  if (r_ok) begin
                     cur <= S_WB;
                  end else begin
                     cur  <= S_TRAP;
                     trap <= 1'b1;
                  end
               end else if (is_addi || is_jal) begin
                  cur <= S_WB;
               end else if (is_lw || is_sw) begin
                  cur <= S_MEM;
               end else if (is_beq) begin
                  retired <= retired + 1'b1;
                  cur     <= S_FETCH;
               end else begin
                  cur  <= S_TRAP;
                  trap <= 1'b1;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (is_lw) begin
                     cur <= S_WB;
                  end else begin
                     retired <= retired + 1'b1;
                     cur     <= S_FETCH;
                  end
               end
            end
            S_WB: begin
               retired <= retired + 1'b1;
               cur     <= S_FETCH;
            end
            S_TRAP: begin
               cur <= S_TRAP;
            end
            default: begin
               cur <= S_FETCH;
            end
         endcase
      end
   end

   // Strobe decode from the current state and latched IR. Holding rst_n
   // low suppresses every strobe so a pending write in MEM or WB is never
   // issued in the reset cycle.
   always_comb begin
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Mem2Reg  = 1'b0;
      Link     = 1'b0;
      op       = ALU_ADD;
      PCWrite  = 1'b0;
      PCSel    = 2'b00;
      case (cur)
         S_FETCH: IRWrite = 1'b1;
         S_EXEC: begin
            if (is_r) begin
               op = r_op;
            end else if (is_addi || is_lw || is_sw) begin
               ALUSrc = 1'b1;
            end else if (is_beq) begin
               op      = ALU_SUB;
               PCWrite = 1'b1;
               PCSel   = zero ? 2'b01 : 2'b00;
            end
         end
         S_MEM: begin
            if (is_lw) begin
               MemRead = 1'b1;
               Mem2Reg = 1'b1;
            end else begin
               MemWrite = 1'b1;
               PCWrite  = mem_ready;
            end
         end
         S_WB: begin
            RegWrite = (rd != 5'd0);
            Mem2Reg  = is_lw;
            Link     = is_jal;
            PCWrite  = 1'b1;
            PCSel    = is_jal ? 2'b10 : 2'b00;
         end
         default: ;
      endcase
      if (!rst_n) begin
         IRWrite  = 1'b0;
         RegWrite = 1'b0;
         ALUSrc   = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         Mem2Reg  = 1'b0;
         Link     = 1'b0;
         PCWrite  = 1'b0;
         PCSel    = 2'b00;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. The counter is narrowed to 4 bits
// so the wrap from 15 to 0 is reachable in a handful of instructions. Each
// table row is one clock cycle: inputs applied after the edge, outputs
// compared before the next edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [31:0]      ins;
   logic             zero;
   logic             mem_ready;
   logic             IRWrite, RegWrite, ALUSrc, MemRead, MemWrite;
   logic             Mem2Reg, Link, PCWrite;
   logic [2:0]       op;
   logic [1:0]       PCSel;
   logic [2:0]       state;
   logic             trap;
   logic [CNT_W-1:0] retired;

   int checks   = 0;
   int failures = 0;
   int expRet   = 0;

   localparam logic [31:0] INS_ADD  = 32'h002081B3;
   localparam logic [31:0] INS_SUB  = 32'h403100B3;
   localparam logic [31:0] INS_OR   = 32'h0020E1B3;
   localparam logic [31:0] INS_AND  = 32'h0020F1B3;
   localparam logic [31:0] INS_SLT  = 32'h0020A1B3;
   localparam logic [31:0] INS_ADDI = 32'h00500093;
   localparam logic [31:0] INS_BEQ  = 32'h00108463;
   localparam logic [31:0] INS_LW   = 32'h00002283;
   localparam logic [31:0] INS_SW   = 32'h00502023;
   localparam logic [31:0] INS_JAL0 = 32'h0080006F;
   localparam logic [31:0] INS_ILL  = 32'h0000007F;
   localparam logic [31:0] INS_BADF = 32'h002091B3;

   typedef struct {
      logic        rst_n;
      logic [31:0] ins;
      logic        zero;
      logic        mem_ready;
      logic [2:0]  st;
      logic [12:0] strb;
      logic        trap;
      logic [3:0]  ret;
      string       name;
   } vec_t;

   vec_t vecs[$];

   multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ins(ins), .zero(zero), .mem_ready(mem_ready),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .Mem2Reg(Mem2Reg), .Link(Link),
      .op(op), .PCWrite(PCWrite), .PCSel(PCSel), .state(state), .trap(trap),
      .retired(retired)
   );

   always #5 clk = ~clk;

   // Safety net so the run always ends even if sequencing goes wrong.
   initial begin
      #100000;
      $display("[TB] FAIL timeout reached before end of test");
      $fatal(1, "[TB] timeout");
   end

   // Expected strobe bundle, ordered
   // {IRWrite,RegWrite,ALUSrc,MemRead,MemWrite,Mem2Reg,Link,PCWrite,PCSel,op}.
   function automatic logic [12:0] mk(input bit irw, input bit rw, input bit as,
                                      input bit mr, input bit mw, input bit m2r,
                                      input bit lk, input bit pw,
                                      input logic [1:0] pcs, input logic [2:0] o);
      return {irw, rw, as, mr, mw, m2r, lk, pw, pcs, o};
   endfunction

   function automatic logic [12:0] idle();
      return mk(0,0,0,0,0,0,0,0,2'b00,3'b010);
   endfunction

   task automatic addVec(input logic r, input logic [31:0] i, input logic z,
                         input logic mr, input logic [2:0] st,
                         input logic [12:0] s, input logic t,
                         input int ret, input string nm);
      vec_t v;
      v.rst_n = r; v.ins = i; v.zero = z; v.mem_ready = mr;
      v.st = st; v.strb = s; v.trap = t; v.ret = 4'(ret); v.name = nm;
      vecs.push_back(v);
   endtask

   // Four-cycle ALU instruction: FETCH, DECODE (garbage on ins), EXEC, WB.
   task automatic addAlu(input logic [31:0] i, input bit as, input logic [2:0] o,
                         input bit rw, input int ret, input string nm);
      addVec(1, i,  0, 0, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, ret, {nm, "_fetch"});
      addVec(1, ~i, 0, 0, 3'd1, idle(), 0, ret, {nm, "_decode"});
      addVec(1, ~i, 0, 0, 3'd2, mk(0,0,as,0,0,0,0,0,2'b00,o), 0, ret, {nm, "_exec"});
      addVec(1, ~i, 0, 0, 3'd4, mk(0,rw,0,0,0,0,0,1,2'b00,3'b010), 0, ret, {nm, "_wb"});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic r, input logic [31:0] i,
                                input logic z, input logic mr);
      rst_n = r; ins = i; zero = z; mem_ready = mr;
      #1;
   endtask

   task automatic checkOutput(input string nm, input logic [2:0] st,
                              input logic [12:0] s, input logic t,
                              input logic [3:0] ret);
      logic [12:0] got;
      got = {IRWrite, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, Link,
             PCWrite, PCSel, op};
      checks++;
      if (state !== st) begin
         failures++;
         $display("[TB] FAIL %s state got=%b want=%b", nm, state, st);
      end
      checks++;
      if (got !== s) begin
         failures++;
         $display("[TB] FAIL %s strobes got=%b want=%b", nm, got, s);
      end
      checks++;
      if (trap !== t) begin
         failures++;
         $display("[TB] FAIL %s trap got=%b want=%b", nm, trap, t);
      end
      checks++;
      if (retired !== ret) begin
         failures++;
         $display("[TB] FAIL %s retired got=%0d want=%0d", nm, retired, ret);
      end
   endtask

   // One beq through FETCH/DECODE/EXEC with the model counter advancing.
   task automatic runBeq(input logic z, input string nm);
      applyStimulus(1, INS_BEQ, z, 0);
      checkOutput({nm, "_fetch"}, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 4'(expRet));
      tick();
      applyStimulus(1, 32'h0, z, 0);
      tick();
      applyStimulus(1, 32'h0, z, 0);
      checkOutput({nm, "_exec"}, 3'd2,
                  mk(0,0,0,0,0,0,0,1, z ? 2'b01 : 2'b00, 3'b110), 0, 4'(expRet));
      tick();
      expRet = (expRet + 1) % (1 << CNT_W);
   endtask

   initial begin
      rst_n = 1'b0; ins = '0; zero = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2;

      // ---------------- directed cycle table ----------------
      addVec(0, 32'h0, 0, 0, 3'd0, idle(), 0, 0, "reset_hold");
      addAlu(INS_ADD, 0, 3'b010, 1, 0, "add");
      addVec(1, INS_BEQ, 1, 0, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 1, "beq1_fetch");
      addVec(1, 32'h0,   1, 0, 3'd1, idle(), 0, 1, "beq1_decode");
      addVec(1, 32'h0,   1, 0, 3'd2, mk(0,0,0,0,0,0,0,1,2'b01,3'b110), 0, 1, "beq1_exec_taken");
      addVec(1, INS_BEQ, 0, 0, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 2, "beq0_fetch");
      addVec(1, 32'h0,   0, 0, 3'd1, idle(), 0, 2, "beq0_decode");
      addVec(1, 32'h0,   0, 0, 3'd2, mk(0,0,0,0,0,0,0,1,2'b00,3'b110), 0, 2, "beq0_exec_fall");
      addVec(1, INS_LW,  0, 0, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 3, "lw_fetch");
      addVec(1, INS_SW,  0, 0, 3'd1, idle(), 0, 3, "lw_decode");
      addVec(1, INS_SW,  0, 0, 3'd2, mk(0,0,1,0,0,0,0,0,2'b00,3'b010), 0, 3, "lw_exec");
      for (int k = 0; k < 3; k++)
         addVec(1, INS_SW, 0, 0, 3'd3, mk(0,0,0,1,0,1,0,0,2'b00,3'b010), 0, 3, "lw_mem_stall");
      addVec(1, INS_SW,  0, 1, 3'd3, mk(0,0,0,1,0,1,0,0,2'b00,3'b010), 0, 3, "lw_mem_ready");
      addVec(1, INS_SW,  0, 0, 3'd4, mk(0,1,0,0,0,1,0,1,2'b00,3'b010), 0, 3, "lw_wb");
      addVec(1, INS_SW,  0, 1, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 4, "sw_fetch");
      addVec(1, INS_LW,  0, 1, 3'd1, idle(), 0, 4, "sw_decode");
      addVec(1, INS_LW,  0, 1, 3'd2, mk(0,0,1,0,0,0,0,0,2'b00,3'b010), 0, 4, "sw_exec");
      addVec(1, INS_LW,  0, 1, 3'd3, mk(0,0,0,0,1,0,0,1,2'b00,3'b010), 0, 4, "sw_mem");
      addAlu(INS_SUB, 0, 3'b110, 1, 5, "sub");
      addVec(1, INS_JAL0, 0, 0, 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 6, "jal_fetch");
      addVec(1, 32'h0,    0, 0, 3'd1, idle(), 0, 6, "jal_decode");
      addVec(1, 32'h0,    0, 0, 3'd2, idle(), 0, 6, "jal_exec");
      addVec(1, 32'h0,    0, 0, 3'd4, mk(0,0,0,0,0,0,1,1,2'b10,3'b010), 0, 6, "jal_wb_rd0");
      addAlu(INS_ADDI, 1, 3'b010, 1, 7,  "addi");
      addAlu(INS_OR,   0, 3'b001, 1, 8,  "or");
      addAlu(INS_AND,  0, 3'b000, 1, 9,  "and");
      addAlu(INS_SLT,  0, 3'b111, 1, 10, "slt");

      foreach (vecs[n]) begin
         applyStimulus(vecs[n].rst_n, vecs[n].ins, vecs[n].zero, vecs[n].mem_ready);
         checkOutput(vecs[n].name, vecs[n].st, vecs[n].strb, vecs[n].trap, vecs[n].ret);
         tick();
      end
      expRet = 11;

      // ---------------- counter wrap 15 -> 0 ----------------
      for (int k = 0; k < 5; k++) runBeq(k[0], "wrap_beq");
      applyStimulus(1, 32'h0, 0, 0);
      checkOutput("wrap_to_zero", 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 4'h0);

      // ---------------- reset during sw MEM stall ----------------
      runBeq(1, "pre_reset_beq");
      applyStimulus(1, INS_SW, 0, 0); tick();
      applyStimulus(1, 32'h0, 0, 0);  tick();
      applyStimulus(1, 32'h0, 0, 0);  tick();
      applyStimulus(1, 32'h0, 0, 0);
      checkOutput("sw_stall", 3'd3, mk(0,0,0,0,1,0,0,0,2'b00,3'b010), 0, 4'(expRet));
      tick();
      applyStimulus(0, 32'h0, 0, 0);
      checkOutput("sw_stall_reset_cycle", 3'd3, idle(), 0, 4'(expRet));
      tick();
      expRet = 0;
      applyStimulus(1, INS_ILL, 0, 0);
      checkOutput("after_stall_reset", 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 4'h0);
      tick();

      // ---------------- illegal opcode trap ----------------
      applyStimulus(1, 32'h0, 0, 0);
      checkOutput("ill_decode", 3'd1, idle(), 0, 4'h0);
      tick();
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1, $urandom, 1'b1, 1'b1);
         checkOutput("ill_trap_hold", 3'd7, idle(), 1, 4'h0);
         tick();
      end
      applyStimulus(0, 32'h0, 0, 0);
      tick();
      applyStimulus(1, INS_BADF, 0, 0);
      checkOutput("trap_cleared", 3'd0, mk(1,0,0,0,0,0,0,0,2'b00,3'b010), 0, 4'h0);
      tick();

      // ---------------- unsupported R-type funct3 ----------------
      applyStimulus(1, 32'h0, 0, 0); tick();
      applyStimulus(1, 32'h0, 0, 0);
      checkOutput("badf3_exec", 3'd2, idle(), 0, 4'h0);
      tick();
      applyStimulus(1, 32'h0, 0, 1);
      checkOutput("badf3_trap", 3'd7, idle(), 1, 4'h0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
